multicycle_controller: RTL and testbench

- Control unit for the multi-cycle RV32I datapath.
- Decodes the instruction-register fields and drives the immediate extender's immsrc, the datapath muxes, the ALU function and the write enables.
- Sequencing is a Moore main FSM; ALU decode and immediate-type decode are combinational.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal, lui.

---
 rtl/multicycle_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Control unit for a multi-cycle RV32I datapath. A Moore main FSM
//             sequences each instruction. Combinational decoders produce the
//             ALU function and the immediate type.
//             Supported instructions: lw, sw, R-type ALU, I-type ALU, beq,
//             jal, lui.
//  Ports    : clk        - rising-edge clock
//             reset      - asynchronous active-high reset, forces FETCH
//             op         - instr[6:0]
//             funct3     - instr[14:12]
//             funct7b5   - instr[30]
//             zero       - ALU zero flag
//             immsrc     - 000 I, 001 S, 010 B, 011 J, 100 U
//             alusrca    - 00 PC, 01 OldPC, 10 rs1
//             alusrcb    - 00 rs2, 01 immext, 10 constant 4
//             resultsrc  - 00 ALUOut, 01 read data, 10 ALU result, 11 immext
//             adrsrc     - 0 PC, 1 Result
//             alucontrol - 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//             irwrite, pcwrite, regwrite, memwrite - write enables
//             illegal    - (ILLEGAL_TRAP_EN only) set while parked in TRAP
//  Options  : `define ILLEGAL_TRAP_EN adds the illegal output. It sends
//             unsupported opcodes and undefined ALU funct3 codes to a
//             TRAP state that can only be left through reset.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [2:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] w_aluop;
  logic       w_branch;
  logic       w_pcupdate;

`ifdef ILLEGAL_TRAP_EN
  // funct3 codes with no supported ALU operation (shifts, sltu)
  logic w_funct3_bad;
  assign w_funct3_bad = (funct3 == 3'b001) || (funct3 == 3'b011) ||
                        (funct3 == 3'b101);
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // --------------------------------------------------------------------------
  // Next state and Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = S_FETCH;
    adrsrc       = 1'b0;
    irwrite      = 1'b0;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    resultsrc    = 2'b00;
    w_aluop      = 2'b00;
    w_branch     = 1'b0;
    w_pcupdate   = 1'b0;
    regwrite     = 1'b0;
    memwrite     = 1'b0;

    case (r_state)
      S_FETCH: begin
        irwrite      = 1'b1;
        alusrcb      = 2'b10;
        resultsrc    = 2'b10;
        w_pcupdate   = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + immext: branch target parked in ALUOut for BEQ
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          c_OP_LW, c_OP_SW: w_next_state = S_MEMADR;
          c_OP_R:           w_next_state = S_EXECUTER;
          c_OP_I:           w_next_state = S_EXECUTEI;
          c_OP_BEQ:         w_next_state = S_BEQ;
          c_OP_JAL:         w_next_state = S_JAL;
          c_OP_LUI:         w_next_state = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:          w_next_state = S_TRAP;
`else
          default:          w_next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca      = 2'b10;
        alusrcb      = 2'b01;
        w_next_state = (op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc       = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        alusrca      = 2'b10;
        alusrcb      = (r_state == S_EXECUTEI) ? 2'b01 : 2'b00;
        w_aluop      = 2'b10;
`ifdef ILLEGAL_TRAP_EN
        w_next_state = w_funct3_bad ? S_TRAP : S_ALUWB;
`else
        w_next_state = S_ALUWB;
`endif
      end
      S_ALUWB: begin
        regwrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BEQ: begin
        alusrca      = 2'b10;
        w_aluop      = 2'b01;
        w_branch     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        // PC <= ALUOut (target); ALU computes OldPC + 4 for the link value
        alusrca      = 2'b01;
        alusrcb      = 2'b10;
        w_pcupdate   = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_LUI: begin
        resultsrc    = 2'b11;
        regwrite     = 1'b1;
        w_next_state = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        w_next_state = S_TRAP;
      end
`endif
      // Unused encodings recover to FETCH on the next edge
      default: w_next_state = S_FETCH;
    endcase
  end

  assign pcwrite = w_pcupdate | (w_branch & zero);

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`endif

  // --------------------------------------------------------------------------
  // ALU decoder
  // --------------------------------------------------------------------------
  always_comb begin
    alucontrol = 3'b000;
    case (w_aluop)
      2'b00: alucontrol = 3'b000;
      2'b01: alucontrol = 3'b001;
      default: begin
        case (funct3)
          // sub only for R-type with funct7[5]; addi never subtracts
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b100:  alucontrol = 3'b100;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Immediate-type decoder
  // --------------------------------------------------------------------------
  always_comb begin
    immsrc = 3'b000;
    case (op)
      c_OP_LW, c_OP_I: immsrc = 3'b000;
      c_OP_SW:         immsrc = 3'b001;
      c_OP_BEQ:        immsrc = 3'b010;
      c_OP_JAL:        immsrc = 3'b011;
      c_OP_LUI:        immsrc = 3'b100;
      default:         immsrc = 3'b000;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Self-checking bench for multicycle_controller. Each instruction
//             is expanded into the cycle-by-cycle list of control words it
//             should produce. Every cycle's outputs are compared against that
//             list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam logic [6:0] c_OP_LW  = 7'b0000011;
  localparam logic [6:0] c_OP_SW  = 7'b0100011;
  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ = 7'b1100011;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;
  localparam logic [6:0] c_OP_LUI = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [2:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .immsrc     (immsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .adrsrc     (adrsrc),
    .alucontrol (alucontrol),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal    (illegal)
`endif
  );

  always #5 clk = ~clk;

  logic [17:0] w_dut_vec;
  assign w_dut_vec = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                      irwrite, pcwrite, regwrite, memwrite};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control word packed in the same field order as w_dut_vec
  function automatic logic [17:0] pk(input logic [2:0] imm, input logic [1:0] asa,
                                     input logic [1:0] asb, input logic [1:0] rs,
                                     input logic adr, input logic [2:0] aluc,
                                     input logic irw, input logic pcw,
                                     input logic rw, input logic mw);
    return {imm, asa, asb, rs, adr, aluc, irw, pcw, rw, mw};
  endfunction

  function automatic bit known(input logic [6:0] o);
    return (o == c_OP_LW) || (o == c_OP_SW) || (o == c_OP_R) || (o == c_OP_I) ||
           (o == c_OP_BEQ) || (o == c_OP_JAL) || (o == c_OP_LUI);
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == c_OP_SW)  return 3'b001;
    if (o == c_OP_BEQ) return 3'b010;
    if (o == c_OP_JAL) return 3'b011;
    if (o == c_OP_LUI) return 3'b100;
    return 3'b000;
  endfunction

  // ALU operation an R/I instruction performs, by mnemonic
  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7);
    if (f3 == 3'b000) return (o == c_OP_R && f7) ? 3'b001 : 3'b000; // sub / add
    if (f3 == 3'b010) return 3'b101; // slt
    if (f3 == 3'b100) return 3'b100; // xor
    if (f3 == 3'b110) return 3'b011; // or
    if (f3 == 3'b111) return 3'b010; // and
    return 3'b000;
  endfunction

  function automatic int len_of(input logic [6:0] o);
    if (o == c_OP_LW) return 5;
    if (o == c_OP_BEQ || o == c_OP_LUI) return 3;
    if (known(o)) return 4;
    return 2;
  endfunction

  // Expected control word in cycle k of an instruction (k=0 is fetch)
  function automatic logic [17:0] exp_step(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7, input logic z, input int k);
    logic [2:0] im;
    im = imm_of(o);
    if (k == 0) return pk(im, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    if (k == 1) return pk(im, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (o == c_OP_LW || o == c_OP_SW) begin
      if (k == 2) return pk(im, 2'd2, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (o == c_OP_SW) return pk(im, 2'd0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (k == 3) return pk(im, 2'd0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      return pk(im, 2'd0, 2'd0, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    if (o == c_OP_R || o == c_OP_I) begin
      if (k == 2) return pk(im, 2'd2, (o == c_OP_I) ? 2'd1 : 2'd0, 2'd0, 1'b0,
                            alu_of(o, f3, f7), 1'b0, 1'b0, 1'b0, 1'b0);
      return pk(im, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    if (o == c_OP_BEQ) return pk(im, 2'd2, 2'd0, 2'd0, 1'b0, 3'd1, 1'b0, z, 1'b0, 1'b0);
    if (o == c_OP_JAL) begin
      if (k == 2) return pk(im, 2'd1, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      return pk(im, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    if (o == c_OP_LUI) return pk(im, 2'd0, 2'd0, 2'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    return pk(im, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Runs one instruction from its fetch cycle. reset_at >= 0 asserts reset
  // part-way through that cycle and abandons the instruction.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input int reset_at);
    int  len;
    bit  trap;
    logic z;
    len  = len_of(o);
    trap = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    if (!known(o)) trap = 1'b1;
    if ((o == c_OP_R || o == c_OP_I) &&
        (f3 == 3'b001 || f3 == 3'b011 || f3 == 3'b101)) begin
      trap = 1'b1;
      len  = 3;
    end
`endif
    op = o; funct3 = f3; funct7b5 = f7;
    for (int k = 0; k < len; k++) begin
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      zero = z;
      #1;
      check($sformatf("op%b_f%b_s%0b_cyc%0d", o, f3, f7, k), w_dut_vec,
            exp_step(o, f3, f7, z, k));
`ifdef ILLEGAL_TRAP_EN
      check("illegal_low", illegal, 1'b0);
`endif
      if (k == reset_at) begin
        #2 reset = 1'b1;
        #1;
        check("async_reset_word", w_dut_vec,
              pk(imm_of(o), 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        check("async_reset_memwrite", memwrite, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    if (trap) begin
      for (int k = 0; k < 3; k++) begin
        zero = 1'($urandom_range(0, 1));
        #1;
        check("trap_word", w_dut_vec,
              pk(imm_of(o), 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef ILLEGAL_TRAP_EN
        check("trap_illegal", illegal, 1'b1);
`endif
        @(posedge clk);
        #1;
      end
      reset = 1'b1;
      #1;
`ifdef ILLEGAL_TRAP_EN
      check("trap_cleared", illegal, 1'b0);
`endif
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [6:0] o;
    int         sel;
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    #12;
    check("reset_word", w_dut_vec,
          pk(3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    // Directed instructions
    run_instr(c_OP_LW,  3'b010, 1'b0, -1, -1);
    run_instr(c_OP_SW,  3'b010, 1'b0, -1, -1);
    run_instr(c_OP_BEQ, 3'b000, 1'b0,  1, -1);
    run_instr(c_OP_BEQ, 3'b000, 1'b0,  0, -1);
    run_instr(c_OP_R,   3'b000, 1'b1, -1, -1);
    run_instr(c_OP_I,   3'b000, 1'b1, -1, -1);
    run_instr(c_OP_R,   3'b110, 1'b0, -1, -1);
    run_instr(c_OP_I,   3'b111, 1'b0, -1, -1);
    run_instr(c_OP_R,   3'b010, 1'b0, -1, -1);
    run_instr(c_OP_I,   3'b100, 1'b0, -1, -1);
    run_instr(c_OP_JAL, 3'b000, 1'b0, -1, -1);
    run_instr(c_OP_LUI, 3'b000, 1'b0, -1, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, -1, -1);
    run_instr(c_OP_SW,  3'b000, 1'b0, -1,  3);
    run_instr(c_OP_LW,  3'b000, 1'b0, -1, -1);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: o = c_OP_LW;
        1: o = c_OP_SW;
        2: o = c_OP_R;
        3: o = c_OP_I;
        4: o = c_OP_BEQ;
        5: o = c_OP_JAL;
        6: o = c_OP_LUI;
        default: begin
          o = 7'($urandom);
          while (known(o)) o = 7'($urandom);
        end
      endcase
      run_instr(o, 3'($urandom), 1'($urandom), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
